// File: rtl/debug_writer.sv
// UART-driven RAM poke engine: decodes CMD/ADDR_HI/ADDR_LO/LEN/data frames and writes the
// Tanh LUT, Conv1 weight RAM or Image RAM. Optional timeout/NAK path: DEBUG_WRITER_TIMEOUT_EN.
module debug_writer #(
    parameter logic [7:0] ACK_BYTE = 8'hA5
`ifdef DEBUG_WRITER_TIMEOUT_EN
    ,
    parameter logic [7:0] NAK_BYTE = 8'hEE,
    parameter int unsigned TIMEOUT_CYCLES = 32'd1_000_000
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_ready,
    output logic        tanh_wr_en,
    output logic [7:0]  tanh_wr_addr,
    output logic [7:0]  tanh_wr_data,
    output logic        conv_wr_en,
    output logic [11:0] conv_wr_addr,
    output logic [7:0]  conv_wr_data,
    output logic        img_wr_en,
    output logic [9:0]  img_wr_addr,
    output logic [7:0]  img_wr_data,
    output logic [7:0]  tx_data,
    output logic        tx_send,
    input  logic        tx_busy,
    output logic        busy
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_HDR_HI = 3'd1;
    localparam logic [2:0] ST_HDR_LO = 3'd2;
    localparam logic [2:0] ST_LEN    = 3'd3;
    localparam logic [2:0] ST_DATA   = 3'd4;
    localparam logic [2:0] ST_ACK    = 3'd5;
    localparam logic [2:0] ST_NAK    = 3'd6;

    logic        rx_prev_q;
    logic        rx_edge_s;
    logic [2:0]  state_q, state_d;
    logic [1:0]  tgt_q, tgt_d;
    logic [11:0] addr_q, addr_d;
    logic [8:0]  cnt_q, cnt_d;
    logic        tanh_en_q, tanh_en_d, conv_en_q, conv_en_d, img_en_q, img_en_d;
    logic [7:0]  tanh_addr_q, tanh_addr_d, tanh_data_q, tanh_data_d;
    logic [11:0] conv_addr_q, conv_addr_d;
    logic [7:0]  conv_data_q, conv_data_d;
    logic [9:0]  img_addr_q, img_addr_d;
    logic [7:0]  img_data_q, img_data_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_send_q, tx_send_d;
    logic        busy_q, busy_d;
`ifdef DEBUG_WRITER_TIMEOUT_EN
    logic [31:0] timer_q, timer_d;
`endif

    assign rx_edge_s = rx_ready & ~rx_prev_q;

    // Next-state and output decode for the frame parser
    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        tanh_en_d   = 1'b0;
        conv_en_d   = 1'b0;
        img_en_d    = 1'b0;
        tanh_addr_d = tanh_addr_q;
        tanh_data_d = tanh_data_q;
        conv_addr_d = conv_addr_q;
        conv_data_d = conv_data_q;
        img_addr_d  = img_addr_q;
        img_data_d  = img_data_q;
        tx_data_d   = tx_data_q;
        tx_send_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rx_edge_s && (rx_data == 8'hE0 || rx_data == 8'hE1 || rx_data == 8'hE2)) begin
                    state_d = ST_HDR_HI;
                    tgt_d   = rx_data[1:0];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HDR_HI: begin
                if (rx_edge_s) begin
                    addr_d[11:8] = rx_data[3:0];
                    state_d      = ST_HDR_LO;
                end else begin
                    state_d = ST_HDR_HI;
                end
            end
            ST_HDR_LO: begin
                if (rx_edge_s) begin
                    addr_d[7:0] = rx_data;
                    state_d     = ST_LEN;
                end else begin
                    state_d = ST_HDR_LO;
                end
            end
            ST_LEN: begin
                if (rx_edge_s) begin
                    cnt_d   = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_LEN;
                end
            end
            ST_DATA: begin
                if (rx_edge_s) begin
                    case (tgt_q)
                        2'd0: begin
                            tanh_en_d   = 1'b1;
                            tanh_addr_d = addr_q[7:0];
                            tanh_data_d = rx_data;
                        end
                        2'd1: begin
                            conv_en_d   = 1'b1;
                            conv_addr_d = addr_q;
                            conv_data_d = rx_data;
                        end
                        2'd2: begin
                            img_en_d   = 1'b1;
                            img_addr_d = addr_q[9:0];
                            img_data_d = rx_data;
                        end
                        default: begin
                            tanh_en_d = 1'b0;
                        end
                    endcase
                    addr_d  = addr_q + 12'd1;
                    cnt_d   = cnt_q - 9'd1;
                    state_d = (cnt_q == 9'd1) ? ST_ACK : ST_DATA;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_ACK, ST_NAK: begin
                // Stay one extra cycle so busy is still high during the send strobe
                if (tx_send_q) begin
                    state_d = ST_IDLE;
                end else if (!tx_busy) begin
                    tx_send_d = 1'b1;
`ifdef DEBUG_WRITER_TIMEOUT_EN
                    tx_data_d = (state_q == ST_NAK) ? NAK_BYTE : ACK_BYTE;
`else
                    tx_data_d = ACK_BYTE;
`endif
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
`ifdef DEBUG_WRITER_TIMEOUT_EN
        if (state_q == ST_HDR_HI || state_q == ST_HDR_LO || state_q == ST_LEN || state_q == ST_DATA) begin
            if (rx_edge_s) begin
                timer_d = 32'd0;
            end else if (timer_q == TIMEOUT_CYCLES - 32'd1) begin
                timer_d = 32'd0;
                state_d = ST_NAK;
            end else begin
                timer_d = timer_q + 32'd1;
            end
        end else begin
            timer_d = 32'd0;
        end
`endif
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_prev_q   <= rx_ready;
            state_q     <= ST_IDLE;
            tgt_q       <= 2'd0;
            addr_q      <= 12'd0;
            cnt_q       <= 9'd0;
            tanh_en_q   <= 1'b0;
            tanh_addr_q <= 8'd0;
            tanh_data_q <= 8'd0;
            conv_en_q   <= 1'b0;
            conv_addr_q <= 12'd0;
            conv_data_q <= 8'd0;
            img_en_q    <= 1'b0;
            img_addr_q  <= 10'd0;
            img_data_q  <= 8'd0;
            tx_data_q   <= 8'd0;
            tx_send_q   <= 1'b0;
            busy_q      <= 1'b0;
`ifdef DEBUG_WRITER_TIMEOUT_EN
            timer_q     <= 32'd0;
`endif
        end else begin
            rx_prev_q   <= rx_ready;
            state_q     <= state_d;
            tgt_q       <= tgt_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            tanh_en_q   <= tanh_en_d;
            tanh_addr_q <= tanh_addr_d;
            tanh_data_q <= tanh_data_d;
            conv_en_q   <= conv_en_d;
            conv_addr_q <= conv_addr_d;
            conv_data_q <= conv_data_d;
            img_en_q    <= img_en_d;
            img_addr_q  <= img_addr_d;
            img_data_q  <= img_data_d;
            tx_data_q   <= tx_data_d;
            tx_send_q   <= tx_send_d;
            busy_q      <= busy_d;
`ifdef DEBUG_WRITER_TIMEOUT_EN
            timer_q     <= timer_d;
`endif
        end
    end

    assign tanh_wr_en   = tanh_en_q;
    assign tanh_wr_addr = tanh_addr_q;
    assign tanh_wr_data = tanh_data_q;
    assign conv_wr_en   = conv_en_q;
    assign conv_wr_addr = conv_addr_q;
    assign conv_wr_data = conv_data_q;
    assign img_wr_en    = img_en_q;
    assign img_wr_addr  = img_addr_q;
    assign img_wr_data  = img_data_q;
    assign tx_data      = tx_data_q;
    assign tx_send      = tx_send_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_debug_writer.sv
// Self-checking bench for debug_writer: table of per-byte vectors plus hand-written
// sequences for LEN=0, level hold, mid-frame reset, tx_busy stall and (optionally) timeout.
module tb_debug_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        tanh_wr_en, conv_wr_en, img_wr_en;
    logic [7:0]  tanh_wr_addr, tanh_wr_data, conv_wr_data, img_wr_data;
    logic [11:0] conv_wr_addr;
    logic [9:0]  img_wr_addr;
    logic [7:0]  tx_data;
    logic        tx_send;
    logic        tx_busy;
    logic        busy;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

`ifdef DEBUG_WRITER_TIMEOUT_EN
    debug_writer #(.TIMEOUT_CYCLES(100)) dut (
`else
    debug_writer dut (
`endif
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready),
        .tanh_wr_en(tanh_wr_en), .tanh_wr_addr(tanh_wr_addr), .tanh_wr_data(tanh_wr_data),
        .conv_wr_en(conv_wr_en), .conv_wr_addr(conv_wr_addr), .conv_wr_data(conv_wr_data),
        .img_wr_en(img_wr_en), .img_wr_addr(img_wr_addr), .img_wr_data(img_wr_data),
        .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy), .busy(busy)
    );

    // Pulse counters sampled just after each active edge
    int n_tanh = 0, n_conv = 0, n_img = 0, n_send = 0, n_busy_rise = 0;
    logic busy_prev = 1'b0;
    always @(posedge clk) begin
        #1;
        if (tanh_wr_en) n_tanh++;
        if (conv_wr_en) n_conv++;
        if (img_wr_en)  n_img++;
        if (tx_send)    n_send++;
        if (busy && !busy_prev) n_busy_rise++;
        busy_prev = busy;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        logic [7:0]  rx;
        logic [2:0]  en;    // {img, conv, tanh} expected in the cycle after the byte
        logic [11:0] addr;
        logic [7:0]  data;
        logic        busy;
        logic        send;  // tx_send expected one cycle later
    } vec_t;

    vec_t vecs[16];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s_tanh, s_conv, s_img, s_send, s_rise;
        bit found;

        vecs[0]  = '{8'h55, 3'b000, 12'h000, 8'h00, 1'b0, 1'b0};
        vecs[1]  = '{8'hE0, 3'b000, 12'h000, 8'h00, 1'b1, 1'b0};
        vecs[2]  = '{8'h00, 3'b000, 12'h000, 8'h00, 1'b1, 1'b0};
        vecs[3]  = '{8'h7C, 3'b000, 12'h000, 8'h00, 1'b1, 1'b0};
        vecs[4]  = '{8'h04, 3'b000, 12'h000, 8'h00, 1'b1, 1'b0};
        vecs[5]  = '{8'h11, 3'b001, 12'h07C, 8'h11, 1'b1, 1'b0};
        vecs[6]  = '{8'h22, 3'b001, 12'h07D, 8'h22, 1'b1, 1'b0};
        vecs[7]  = '{8'h33, 3'b001, 12'h07E, 8'h33, 1'b1, 1'b0};
        vecs[8]  = '{8'h44, 3'b001, 12'h07F, 8'h44, 1'b1, 1'b1};
        vecs[9]  = '{8'hE2, 3'b000, 12'h000, 8'h00, 1'b1, 1'b0};
        vecs[10] = '{8'h03, 3'b000, 12'h000, 8'h00, 1'b1, 1'b0};
        vecs[11] = '{8'hFE, 3'b000, 12'h000, 8'h00, 1'b1, 1'b0};
        vecs[12] = '{8'h03, 3'b000, 12'h000, 8'h00, 1'b1, 1'b0};
        vecs[13] = '{8'hAA, 3'b100, 12'h3FE, 8'hAA, 1'b1, 1'b0};
        vecs[14] = '{8'hBB, 3'b100, 12'h3FF, 8'hBB, 1'b1, 1'b0};
        vecs[15] = '{8'hCC, 3'b100, 12'h000, 8'hCC, 1'b1, 1'b1};

        rst = 1'b1; rx_data = 8'h00; rx_ready = 1'b0; tx_busy = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_wr", {tanh_wr_en, conv_wr_en, img_wr_en, tanh_wr_addr, img_wr_addr}, 32'd0);
        check("reset_wr_data", {tanh_wr_data, conv_wr_data, img_wr_data}, 32'd0);
        check("reset_tx", {conv_wr_addr, tx_data, tx_send, busy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Table: noise byte, Tanh frame, Image frame with address wrap
        for (int i = 0; i < 16; i++) begin
            rx_data  = vecs[i].rx;
            rx_ready = 1'b1;
            @(negedge clk);
            check($sformatf("v%0d_en", i), {29'd0, img_wr_en, conv_wr_en, tanh_wr_en}, {29'd0, vecs[i].en});
            check($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].busy});
            case (vecs[i].en)
                3'b001: check($sformatf("v%0d_tanh", i), {16'd0, tanh_wr_addr, tanh_wr_data},
                              {16'd0, vecs[i].addr[7:0], vecs[i].data});
                3'b010: check($sformatf("v%0d_conv", i), {12'd0, conv_wr_addr, conv_wr_data},
                              {12'd0, vecs[i].addr, vecs[i].data});
                3'b100: check($sformatf("v%0d_img", i), {14'd0, img_wr_addr, img_wr_data},
                              {14'd0, vecs[i].addr[9:0], vecs[i].data});
                default: ;
            endcase
            rx_ready = 1'b0;
            @(negedge clk);
            check($sformatf("v%0d_gap_en", i), {29'd0, img_wr_en, conv_wr_en, tanh_wr_en}, 32'd0);
            check($sformatf("v%0d_send", i), {31'd0, tx_send}, {31'd0, vecs[i].send});
            if (vecs[i].send) begin
                check($sformatf("v%0d_ack", i), {24'd0, tx_data}, 32'h0000_00A5);
                @(negedge clk);
                check($sformatf("v%0d_idle", i), {30'd0, busy, tx_send}, 32'd0);
            end
        end

        // LEN=0 means 256 conv writes
        send_byte(8'hE1); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        for (int i = 0; i < 256; i++) begin
            rx_data  = i[7:0];
            rx_ready = 1'b1;
            @(negedge clk);
            check($sformatf("len0_wr%0d", i), {3'd0, tanh_wr_en, conv_wr_en, img_wr_en, 6'd0, conv_wr_addr, conv_wr_data},
                  {3'd0, 3'b010, 6'd0, i[11:0], i[7:0]});
            rx_ready = 1'b0;
            @(negedge clk);
            check($sformatf("len0_send%0d", i), {31'd0, tx_send}, {31'd0, (i == 255)});
        end
        check("len0_ack", {24'd0, tx_data}, 32'h0000_00A5);
        @(negedge clk);

        // Noise then a command held high: exactly one byte consumed
        s_tanh = n_tanh; s_conv = n_conv; s_img = n_img; s_send = n_send; s_rise = n_busy_rise;
        send_byte(8'h55);
        rx_data = 8'hE0; rx_ready = 1'b1;
        repeat (50) @(negedge clk);
        rx_ready = 1'b0;
        @(negedge clk);
        check("hold_writes", n_tanh + n_conv + n_img - s_tanh - s_conv - s_img, 32'd0);
        check("hold_busy_rise", n_busy_rise - s_rise, 32'd1);
        check("hold_busy", {31'd0, busy}, 32'd1);
        send_byte(8'h00); send_byte(8'h10); send_byte(8'h01); send_byte(8'h77);
        @(negedge clk);
        check("hold_tanh_cnt", n_tanh - s_tanh, 32'd1);
        check("hold_tanh_wr", {16'd0, tanh_wr_addr, tanh_wr_data}, 32'h0000_1077);
        check("hold_send", n_send - s_send, 32'd1);

        // Reset after 2 of 4 data bytes
        send_byte(8'hE2); send_byte(8'h00); send_byte(8'h20); send_byte(8'h04);
        s_img = n_img; s_send = n_send;
        send_byte(8'hAA); send_byte(8'hBB);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_outs", {4'd0, img_wr_en, img_wr_addr, tx_data, tx_send, 8'd0}, 32'd0);
        send_byte(8'hCC); send_byte(8'hDD);
        repeat (5) @(negedge clk);
        check("rst_img_cnt", n_img - s_img, 32'd2);
        check("rst_no_send", n_send - s_send, 32'd0);
        check("rst_idle", {31'd0, busy}, 32'd0);

        // tx_busy stall at ACK
        send_byte(8'hE0); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
        s_send = n_send;
        tx_busy = 1'b1;
        send_byte(8'h99);
        repeat (100) @(negedge clk);
        check("stall_no_send", n_send - s_send, 32'd0);
        check("stall_busy", {31'd0, busy}, 32'd1);
        tx_busy = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (tx_send) found = 1'b1;
        end
        check("stall_send_seen", {31'd0, found}, 32'd1);
        check("stall_ack", {24'd0, tx_data}, 32'h0000_00A5);
        @(negedge clk);
        check("stall_busy_drop", {30'd0, busy, tx_send}, 32'd0);

`ifdef DEBUG_WRITER_TIMEOUT_EN
        // Partial header then silence: NAK after the timeout
        send_byte(8'hE1); send_byte(8'h00); send_byte(8'h10);
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            if (tx_send) begin
                found = 1'b1;
                check("to_not_early", {31'd0, (k >= 95)}, 32'd1);
            end
        end
        check("to_send_seen", {31'd0, found}, 32'd1);
        check("to_nak", {24'd0, tx_data}, 32'h0000_00EE);
        @(negedge clk);
        check("to_idle", {31'd0, busy}, 32'd0);
        s_conv = n_conv;
        send_byte(8'hE1); send_byte(8'h00); send_byte(8'h05); send_byte(8'h01); send_byte(8'h5A);
        @(negedge clk);
        check("to_after_conv", n_conv - s_conv, 32'd1);
        check("to_after_wr", {12'd0, conv_wr_addr, conv_wr_data}, 32'h0000_055A);
        check("to_after_ack", {24'd0, tx_data}, 32'h0000_00A5);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
